// File: rtl/timer_irq_ctrl.sv
// Machine-timer interrupt controller: prescaled 64-bit mtime, 64-bit mtimecmp
// comparator, and an interrupt sequencer with optional periodic auto-reload.
module timer_irq_ctrl #(
  parameter int X_LEN      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [X_LEN-1:0] cfg_wdata,
  output logic [X_LEN-1:0] cfg_rdata,
  input  logic             enable_design,
  input  logic             irq_prep,
  input  logic             mret_inst,
  output logic             timer_timeout,
  output logic             mtip_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PENDING = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [63:0]             mtime, mtimecmp;
  logic [31:0]             period;
  logic [PRESCALE_W-1:0]   presc, pcnt;
  logic                    en, auto_reload;
  logic                    cmp, tick, reload, clear_en;

  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_period;

  assign wr_mtime_lo = cfg_we && (cfg_addr == 3'd0);
  assign wr_mtime_hi = cfg_we && (cfg_addr == 3'd1);
  assign wr_cmp_lo   = cfg_we && (cfg_addr == 3'd2);
  assign wr_cmp_hi   = cfg_we && (cfg_addr == 3'd3);
  assign wr_ctrl     = cfg_we && (cfg_addr == 3'd4);
  assign wr_period   = cfg_we && (cfg_addr == 3'd6);

  assign cmp    = (mtime >= mtimecmp);
  // The comparator is true for all-zero registers, so hold the mirror low during reset.
  assign mtip_o = cmp & ~reset;

  // NOTE: asynchronous reset lives in the sensitivity list; every flop here is a
  // plain register (no memories), so all of them can be cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer_timeout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops sample
      // pre-edge values regardless of statement order.
      state         <= state_next;
      timer_timeout <= (state_next == PENDING);
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = COUNT;
        COUNT:   if (cmp) state_next = PENDING;
        PENDING: begin
          if (irq_prep)  state_next = SERVICE;
          else if (!cmp) state_next = COUNT;
        end
        SERVICE: if (mret_inst) state_next = auto_reload ? COUNT : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    tick     = en && enable_design;
    reload   = en && (state == SERVICE) && mret_inst && auto_reload
               && !(wr_cmp_lo || wr_cmp_hi);
    clear_en = en && (state == SERVICE) && mret_inst && !auto_reload;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime       <= '0;
      mtimecmp    <= '0;
      period      <= '0;
      presc       <= '0;
      pcnt        <= '0;
      en          <= 1'b0;
      auto_reload <= 1'b0;
    end else begin
      // A software write to mtime suppresses that cycle's increment entirely.
      if (wr_mtime_lo || wr_mtime_hi) begin
        if (wr_mtime_lo) mtime[31:0]  <= cfg_wdata[31:0];
        if (wr_mtime_hi) mtime[63:32] <= cfg_wdata[31:0];
        pcnt <= '0;
      end else if (tick) begin
        if (pcnt == presc) begin
          pcnt  <= '0;
          mtime <= mtime + 64'd1;
        end else begin
          pcnt <= pcnt + PRESCALE_W'(1);
        end
      end

      if (reload)    mtimecmp        <= mtimecmp + {32'd0, period};
      if (wr_cmp_lo) mtimecmp[31:0]  <= cfg_wdata[31:0];
      if (wr_cmp_hi) mtimecmp[63:32] <= cfg_wdata[31:0];

      if (wr_ctrl) begin
        en          <= cfg_wdata[0];
        auto_reload <= cfg_wdata[1];
        presc       <= cfg_wdata[8 +: PRESCALE_W];
      end else if (clear_en) begin
        en <= 1'b0;
      end

      if (wr_period) period <= cfg_wdata[31:0];
    end
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      3'd0:    cfg_rdata = X_LEN'(mtime[31:0]);
      3'd1:    cfg_rdata = X_LEN'(mtime[63:32]);
      3'd2:    cfg_rdata = X_LEN'(mtimecmp[31:0]);
      3'd3:    cfg_rdata = X_LEN'(mtimecmp[63:32]);
      3'd4:    cfg_rdata = X_LEN'({presc, 6'd0, auto_reload, en});
      3'd5:    cfg_rdata = X_LEN'({1'b0, state, timer_timeout});
      3'd6:    cfg_rdata = X_LEN'(period);
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model of the timer.
module tb_timer_irq_ctrl;
  localparam int X_LEN = 32;
  localparam int PW    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [X_LEN-1:0] cfg_wdata;
  logic [X_LEN-1:0] cfg_rdata;
  logic             enable_design, irq_prep, mret_inst;
  logic             timer_timeout, mtip_o;

  timer_irq_ctrl #(.X_LEN(X_LEN), .PRESCALE_W(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_rdata     (cfg_rdata),
    .enable_design (enable_design),
    .irq_prep      (irq_prep),
    .mret_inst     (mret_inst),
    .timer_timeout (timer_timeout),
    .mtip_o        (mtip_o)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the timer as plain 64-bit arithmetic and a phase number
  // (0 idle, 1 counting, 2 interrupt pending, 3 in handler).
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_period;
  logic [7:0]  m_presc, m_pcnt;
  bit          m_en, m_auto, m_tt;
  int          m_phase;

  task automatic model_reset();
    m_mtime = 0; m_cmp = 0; m_period = 0; m_presc = 0; m_pcnt = 0;
    m_en = 0; m_auto = 0; m_tt = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_mtime[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {16'd0, m_presc, 6'd0, m_auto, m_en};
      3'd5:    return 32'(m_phase * 2 + int'(m_tt));
      3'd6:    return m_period;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit we, input logic [2:0] a, input logic [31:0] d,
                            input bit ena, input bit prep, input bit mret);
    bit fired  = (m_mtime >= m_cmp);
    bit cmp_wr = we && (a == 3'd2 || a == 3'd3);
    bit in_isr_return = m_en && m_phase == 3 && mret;
    int nxt = m_phase;
    if (!m_en) nxt = 0;
    else if (m_phase == 0) nxt = 1;
    else if (m_phase == 1 && fired) nxt = 2;
    else if (m_phase == 2 && prep) nxt = 3;
    else if (m_phase == 2 && !fired) nxt = 1;
    else if (m_phase == 3 && mret) nxt = m_auto ? 1 : 0;

    if (we && a <= 3'd1) begin
      if (a == 3'd0) m_mtime[31:0] = d; else m_mtime[63:32] = d;
      m_pcnt = 0;
    end else if (m_en && ena) begin
      if (m_pcnt == m_presc) begin m_pcnt = 0; m_mtime = m_mtime + 1; end
      else m_pcnt = m_pcnt + 1;
    end

    if (in_isr_return && m_auto && !cmp_wr) m_cmp = m_cmp + 64'(m_period);
    if (we && a == 3'd2) m_cmp[31:0]  = d;
    if (we && a == 3'd3) m_cmp[63:32] = d;

    if (we && a == 3'd4) begin
      m_en = d[0]; m_auto = d[1]; m_presc = d[15:8];
    end else if (in_isr_return && !m_auto) begin
      m_en = 0;
    end
    if (we && a == 3'd6) m_period = d;

    m_phase = nxt;
    m_tt    = (nxt == 2);
  endtask

  // One clock of stimulus: starts and ends just after a falling edge.
  task automatic cyc(input bit we, input logic [2:0] a, input logic [31:0] d,
                     input bit ena, input bit prep, input bit mret);
    cfg_we = we; cfg_addr = a; cfg_wdata = d;
    enable_design = ena; irq_prep = prep; mret_inst = mret;
    #1;
    check("timer_timeout", timer_timeout, m_tt);
    check("mtip", mtip_o, m_mtime >= m_cmp);
    check("rdata", cfg_rdata, model_read(a));
    @(posedge clk);
    model_step(we, a, d, ena, prep, mret);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b0, 3'($urandom_range(0, 7)), 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_tt(input string tag, input bit level, input int max_cycles);
    int k = 0;
    while (timer_timeout !== level && k < max_cycles) begin
      run(1);
      k++;
    end
    check(tag, timer_timeout, level);
  endtask

  task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
    cfg_we = 1'b0; cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  // Asserts reset 2 ns after a falling edge, so the outputs must drop with no clock edge.
  task automatic do_reset(input string tag);
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    enable_design = 0; irq_prep = 0; mret_inst = 0;
    #2 reset = 1'b1;
    #1;
    check({tag, "_async_tt"}, timer_timeout, 1'b0);
    check({tag, "_async_mtip"}, mtip_o, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) peek({tag, "_reg_clear"}, 3'(i), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    enable_design = 0; irq_prep = 0; mret_inst = 0;
    model_reset();
    @(negedge clk);
    do_reset("init");

    // Basic fire at mtime == 10 with no prescaling.
    wr(3'd2, 32'd10);
    wr(3'd4, 32'h1);
    wait_tt("t1_fire", 1'b1, 40);
    peek("t1_status", 3'd5, 32'h5);
    run(3);

    // Prescale by 4 with compare at 2.
    do_reset("t2");
    wr(3'd2, 32'd2);
    wr(3'd4, 32'h0301);
    wait_tt("t2_fire", 1'b1, 40);
    run(2);

    // Acknowledge, then MRET with auto-reload of period 5.
    do_reset("t3");
    wr(3'd6, 32'd5);
    wr(3'd2, 32'd10);
    wr(3'd4, 32'h3);
    wait_tt("t3_fire", 1'b1, 40);
    cyc(1'b0, 3'd5, 32'd0, 1'b1, 1'b1, 1'b0);
    check("t3_ack_drop", timer_timeout, 1'b0);
    run(2);
    cyc(1'b0, 3'd2, 32'd0, 1'b1, 1'b0, 1'b1);
    peek("t3_cmp_reloaded", 3'd2, 32'd15);
    wait_tt("t3_refire", 1'b1, 40);

    // Software clear from pending, then non-periodic return to idle.
    wr(3'd2, 32'hFFFF_FFFF);
    run(1);
    peek("t4_status_count", 3'd5, 32'h2);
    wr(3'd4, 32'h1);
    wr(3'd2, 32'd0);
    wait_tt("t4_fire", 1'b1, 10);
    cyc(1'b0, 3'd5, 32'd0, 1'b1, 1'b1, 1'b0);
    run(2);
    cyc(1'b0, 3'd5, 32'd0, 1'b1, 1'b0, 1'b1);
    peek("t4_en_cleared", 3'd4, 32'h0);
    run(3);

    // mtime wrap across 2^64.
    do_reset("t5");
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd1);
    wr(3'd4, 32'h1);
    run(10);
    peek("t5_wrapped_hi", 3'd1, 32'd0);

    // Compare value 0 fires right after enabling; then reset mid-pending.
    do_reset("t6");
    wr(3'd4, 32'h1);
    wait_tt("t6_cmp0_fire", 1'b1, 5);
    do_reset("t6_midpend");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit we = ($urandom_range(0, 9) == 0);
      logic [2:0] a = 3'($urandom_range(0, 7));
      logic [31:0] d = 32'd0;
      if (we) begin
        case (a)
          3'd0, 3'd2: d = $urandom_range(0, 60);
          3'd1, 3'd3: d = ($urandom_range(0, 15) == 0) ? $urandom : 32'd0;
          3'd4: d = {16'd0, 8'($urandom_range(0, 3)), 6'd0, 1'($urandom),
                     1'($urandom_range(0, 4) != 0)};
          3'd6: d = $urandom_range(0, 20);
          default: d = $urandom;
        endcase
      end
      if ($urandom_range(0, 499) == 0) do_reset("rand");
      else cyc(we, a, d, $urandom_range(0, 9) != 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
